spio_pwm: RTL and testbench

- Second-generation special-purpose I/O peripheral for the Wishbone peripheral bus.
- Drives up to 16 LEDs and reads up to 16 buttons.
- LED writes are masked. Each button has its own debounce counter. Button rising edges are latched as sticky events, cleared by write-1-to-clear, and gated by a per-button interrupt enable. All LEDs share one global PWM brightness.
- Sits on the bus next to other single-cycle peripherals. o_int feeds the interrupt controller.

---
 rtl/spio_pwm.sv | 133 +++++++++++++
 tb/tb_spio_pwm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spio_pwm.sv
// Wishbone LED/button peripheral: masked LED writes, debounced buttons with
// sticky W1C rise events and interrupt enables, and one shared PWM brightness.
module spio_pwm #(
  parameter int NLEDS    = 8,
  parameter int NBTN     = 8,
  parameter int DEBOUNCE = 16,
  parameter int PWM_DIV  = 64
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [1:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  input  logic [3:0]       i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  input  logic [NBTN-1:0]  i_btn,
  output logic [NLEDS-1:0] o_led,
  output logic             o_int
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [NLEDS-1:0] led_q;
  logic [7:0]       bright_q;
  logic [NBTN-1:0]  inten_q, events_q;
  logic [NBTN-1:0]  sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [CW-1:0]    db_cnt_q [NBTN];
  logic [PW-1:0]    presc_q;
  logic [7:0]       pwm_cnt_q;

  logic             bus_req, bus_wr;
  logic [31:0]      rd_data;
  logic [NLEDS-1:0] led_mask, led_val;
  logic [NBTN-1:0]  ev_clr, ev_rise;
  logic             lit;
  logic             unused_ok;

  assign o_wb_stall = 1'b0;
  assign bus_req    = i_wb_cyc && i_wb_stb;
  assign bus_wr     = bus_req && i_wb_we;
  assign led_mask   = i_wb_data[16 +: NLEDS];
  assign led_val    = i_wb_data[NLEDS-1:0];
  assign ev_rise    = deb_q & ~deb_prev_q;
  assign ev_clr     = (bus_wr && i_wb_addr == 2'd1) ? i_wb_data[16 +: NBTN] : '0;
  assign lit        = (bright_q == 8'hff) || (pwm_cnt_q < bright_q);
  assign unused_ok  = ^{i_wb_sel[3:2], i_wb_data};

  always_comb begin
    rd_data = 32'h0;
    case (i_wb_addr)
      2'd0: rd_data = 32'(led_q);
      2'd1: rd_data = {16'(events_q), 16'(deb_q)};
      2'd2: rd_data = 32'(inten_q);
      2'd3: rd_data = {24'h0, bright_q};
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= 32'h0;
      led_q     <= '0;
      bright_q  <= 8'hff;
      inten_q   <= '0;
      events_q  <= '0;
      o_int     <= 1'b0;
      o_led     <= '0;
    end else begin
      o_wb_ack  <= bus_req;
      o_wb_data <= bus_req ? rd_data : 32'h0;
      if (bus_wr) begin
        case (i_wb_addr)
          2'd0: begin
            if (i_wb_sel[1:0] == 2'b11)
              led_q <= (led_q & ~led_mask) | (led_val & led_mask);
            else if (i_wb_sel[0])
              led_q <= led_val;
          end
          2'd2: inten_q  <= i_wb_data[NBTN-1:0];
          2'd3: bright_q <= i_wb_data[7:0];
          default: ;
        endcase
      end
      // a rise landing in the same cycle as its clear stays set
      events_q <= (events_q & ~ev_clr) | ev_rise;
      o_int    <= |(events_q & inten_q);
      o_led    <= led_q & {NLEDS{lit}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CW'(DEBOUNCE - 1)) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= 8'h0;
    end else if (presc_q == PW'(PWM_DIV - 1)) begin
      presc_q   <= '0;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end else begin
      presc_q   <= presc_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_spio_pwm.sv
// Bench for spio_pwm: random register traffic, button pulse widths and PWM
// brightness checked against a behavioural model of the register map.
module tb_spio_pwm;
  localparam int D = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdat = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic [7:0]  btn = 8'h0;
  wire         stall, ack, irq;
  wire  [31:0] rdat;
  wire  [7:0]  led;

  int n_checks = 0, n_err = 0, cyc_n = 0;

  logic [7:0] led_m, inten_m, bright_m, ev_m, deb_m;

  spio_pwm #(.NLEDS(8), .NBTN(8), .DEBOUNCE(D), .PWM_DIV(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdat),
    .i_btn(btn), .o_led(led), .o_int(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    check("stall", 32'(stall), 32'h0);
    tick();
    check("ack", 32'(ack), 32'h1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    check("ack_len", 32'(ack), 32'h0);
    check("rdat_idle", rdat, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    bus(1'b1, a, d, s, r);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'h0, 4'h0, r);
    check(tag, r, exp);
  endtask

  // each LED bit follows the written value where masked, else keeps its state
  function automatic logic [7:0] led_model(input logic [7:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
    logic [7:0] n;
    n = old;
    if (s[1:0] == 2'b11) begin
      for (int i = 0; i < 8; i++) if (d[16+i]) n[i] = d[i];
    end else if (s[0]) begin
      n = d[7:0];
    end
    return n;
  endfunction

  task automatic count_lit(output int n, output int bad);
    n = 0; bad = 0;
    for (int t = 0; t < 256; t++) begin
      tick();
      if (led == 8'hff) n++;
      else if (led != 8'h00) bad++;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  s;
    int first, w, n, bad, r;

    led_m = 0; inten_m = 0; bright_m = 8'hff; ev_m = 0; deb_m = 0;
    repeat (3) tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_int", 32'(irq), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    tick();
    rd_chk("rst_reg0", 2'd0, 32'h0);
    rd_chk("rst_reg1", 2'd1, 32'h0);
    rd_chk("rst_reg2", 2'd2, 32'h0);
    rd_chk("rst_reg3", 2'd3, 32'h0000_00ff);

    wr(2'd0, 32'h0000_00a5, 4'b0001);
    wr(2'd0, 32'h00f0_0050, 4'b0011);
    check("led_out_55", 32'(led), 32'h55);
    rd_chk("led_masked", 2'd0, 32'h55);
    led_m = 8'h55;

    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      wr(2'd0, d, s);
      led_m = led_model(led_m, d, s);
      rd_chk("led_rand", 2'd0, 32'(led_m));
    end
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      wr(2'd2, d, 4'hf);
      inten_m = d[7:0];
      rd_chk("inten_rand", 2'd2, 32'(inten_m));
      d = $urandom;
      wr(2'd3, d, 4'hf);
      bright_m = d[7:0];
      rd_chk("bright_rand", 2'd3, 32'(bright_m));
    end
    wr(2'd3, 32'hff, 4'hf);
    wr(2'd2, 32'h0, 4'hf);
    inten_m = 0; bright_m = 8'hff;

    btn[2] = 1'b1;
    repeat (10) tick();
    btn[2] = 1'b0;
    repeat (30) tick();
    rd_chk("glitch", 2'd1, 32'h0);

    // the rise is visible on the bus one registered stage after debounced flips
    btn[2] = 1'b1;
    first = -1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (rdat[2] && first < 0) first = t;
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    check("deb_latency", 32'(first), 32'(D + 3));
    deb_m = 8'h04; ev_m = 8'h04;
    rd_chk("btn_event", 2'd1, {16'(ev_m), 16'(deb_m)});

    wr(2'd2, 32'h4, 4'hf);
    inten_m = 8'h04;
    check("int_set", 32'(irq), 32'h1);
    wr(2'd1, 32'h0004_0000, 4'hf);
    ev_m = 0;
    check("int_clr", 32'(irq), 32'h0);
    rd_chk("ev_cleared", 2'd1, 32'h0000_0004);

    btn[2] = 1'b0;
    repeat (40) tick();
    deb_m = 0;
    rd_chk("falling_ignored", 2'd1, 32'h0);
    btn[2] = 1'b1;
    repeat (D + 2) tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd1; wdat = 32'h0004_0000;
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    deb_m = 8'h04; ev_m = 8'h04;
    rd_chk("set_wins", 2'd1, {16'(ev_m), 16'(deb_m)});
    check("int_set2", 32'(irq), 32'h1);

    for (int i = 0; i < 6; i++) begin
      w = (i < 2) ? (D - 1 + i) : $urandom_range(4, 30);
      btn[5] = 1'b1;
      repeat (w) tick();
      btn[5] = 1'b0;
      repeat (D + 8) tick();
      if (w >= D) ev_m[5] = 1'b1;
      rd_chk("btn_rand", 2'd1, {16'(ev_m), 16'(deb_m)});
      wr(2'd1, 32'h0020_0000, 4'hf);
      ev_m[5] = 1'b0;
    end

    wr(2'd0, 32'hff, 4'b0001);
    led_m = 8'hff;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: d = 32'd64;
        1: d = 32'd0;
        2: d = 32'd255;
        default: d = 32'($urandom_range(0, 255));
      endcase
      wr(2'd3, d, 4'hf);
      tick(); tick();
      count_lit(n, bad);
      check("pwm_lit", 32'(n), (d == 32'd255) ? 32'd256 : d);
      check("pwm_level", 32'(bad), 32'h0);
    end

    btn = 8'h0;
    repeat (D + 8) tick();
    rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd3; wdat = 32'h12; sel = 4'hf;
    tick();
    r = cyc_n;
    check("rst_wr_ack", 32'(ack), 32'h0);
    check("rst_wr_led", 32'(led), 32'h0);
    rst_n = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    check("rst_wr_ack2", 32'(ack), 32'h0);
    rd_chk("rst_wr_bright", 2'd3, 32'hff);
    rd_chk("rst_wr_inten", 2'd2, 32'h0);
    rd_chk("rst_wr_events", 2'd1, 32'h0);
    rd_chk("rst_wr_led_reg", 2'd0, 32'h0);
    wr(2'd0, 32'hff, 4'b0001);
    wr(2'd3, 32'h1, 4'hf);
    // with BRIGHT=1 the LEDs light only when the PWM counter is 0
    first = -1;
    for (int t = 0; t < 300 && first < 0; t++) begin
      tick();
      if (led == 8'hff) first = cyc_n - r;
    end
    check("pwm_restart", 32'(first), 32'd257);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
